// File: rtl/sfifo_pkt_arbiter.sv
// sfifo_pkt_arbiter
//   Shares the slow FIFO write port between NSRC packet sources. One source is
//   granted at a time. Each packet goes out as a PID word, then a header word
//   {src_id, len, pkt_cnt}, then len payload words pulled from the source.
//   fifo_prog_full is only looked at when a grant is made, so the FIFO
//   threshold must leave room for a whole maximum-length packet.
//   Optional feature macro: SFIFO_ARB_STRICT_PRIO_EN
//     defined   -> fixed priority, lowest index wins
//     undefined -> round-robin, starting after the last granted source
module sfifo_pkt_arbiter #(
  parameter int          NSRC        = 3,
  parameter int          SFIFO_WIDTH = 32,
  parameter int          LEN_W       = 5,
  parameter int          MAX_LEN     = 16,
  parameter logic [31:0] PID         = 32'h4142504d
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clr_cnt,
  input  logic [NSRC-1:0]             src_req,
  input  logic [NSRC*LEN_W-1:0]       src_len,
  input  logic [NSRC*SFIFO_WIDTH-1:0] src_data,
  input  logic                        fifo_prog_full,
  output logic [NSRC-1:0]             src_gnt,
  output logic [LEN_W-1:0]            src_word_idx,
  output logic [NSRC-1:0]             src_done,
  output logic                        fifo_wr,
  output logic [SFIFO_WIDTH-1:0]      fifo_din,
  output logic                        busy,
  output logic [15:0]                 pkt_cnt,
  output logic [15:0]                 stall_cnt
);

  localparam int              IDX_W     = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Registered state and outputs
  state_t                 state_r;
  logic [NSRC-1:0]        gnt_r;
  logic [IDX_W-1:0]       gnt_idx_r;
  logic [LEN_W-1:0]       len_r;
  logic [LEN_W-1:0]       idx_r;
  logic [NSRC-1:0]        done_r;
  logic                   wr_r;
  logic [SFIFO_WIDTH-1:0] din_r;
  logic                   busy_r;
  logic [15:0]            pkt_cnt_r;
  logic [15:0]            stall_cnt_r;
`ifndef SFIFO_ARB_STRICT_PRIO_EN
  logic [IDX_W-1:0]       rr_r;
  logic [IDX_W-1:0]       rr_nxt_s;
`endif

  // Next-state values
  state_t                 state_nxt_s;
  logic [NSRC-1:0]        gnt_nxt_s;
  logic [IDX_W-1:0]       gnt_idx_nxt_s;
  logic [LEN_W-1:0]       len_nxt_s;
  logic [LEN_W-1:0]       idx_nxt_s;
  logic [NSRC-1:0]        done_nxt_s;
  logic                   wr_nxt_s;
  logic [SFIFO_WIDTH-1:0] din_nxt_s;
  logic                   busy_nxt_s;
  logic [15:0]            pkt_cnt_nxt_s;
  logic [15:0]            stall_cnt_nxt_s;

  // Arbitration and source-side muxes
  logic                   pick_found_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [LEN_W-1:0]       pick_len_s;
  logic [LEN_W-1:0]       pick_len_clamped_s;
  logic [SFIFO_WIDTH-1:0] word_s;
  logic [31:0]            hdr_s;

  // Choose the requester to grant in IDLE.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
`ifdef SFIFO_ARB_STRICT_PRIO_EN
    for (int j = 0; j < NSRC; j++) begin
      if (!pick_found_s && src_req[j]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IDX_W'(j);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
`else
    // Search rr+1, rr+2, ... wrapping, so the last granted source goes last.
    for (int k = 1; k <= NSRC; k++) begin
      for (int j = 0; j < NSRC; j++) begin
        if (!pick_found_s && src_req[j] && (j == ((int'(rr_r) + k) % NSRC))) begin
          pick_found_s = 1'b1;
          pick_idx_s   = IDX_W'(j);
        end else begin
          pick_found_s = pick_found_s;
        end
      end
    end
`endif
  end

  // Select length of the chosen requester and payload word of the granted one.
  always_comb begin
    pick_len_s = '0;
    word_s     = '0;
    for (int j = 0; j < NSRC; j++) begin
      if (pick_idx_s == IDX_W'(j)) begin
        pick_len_s = src_len[j*LEN_W +: LEN_W];
      end else begin
        pick_len_s = pick_len_s;
      end
      if (gnt_idx_r == IDX_W'(j)) begin
        word_s = src_data[j*SFIFO_WIDTH +: SFIFO_WIDTH];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Clamp oversize requests and build the second header word.
  always_comb begin
    if (pick_len_s > MAX_LEN_L) begin
      pick_len_clamped_s = MAX_LEN_L;
    end else begin
      pick_len_clamped_s = pick_len_s;
    end
    hdr_s = {8'(gnt_idx_r), 8'(len_r), pkt_cnt_r};
  end

  // Packet FSM: next state and next register values.
  always_comb begin
    state_nxt_s     = state_r;
    gnt_nxt_s       = gnt_r;
    gnt_idx_nxt_s   = gnt_idx_r;
    len_nxt_s       = len_r;
    idx_nxt_s       = idx_r;
    done_nxt_s      = '0;
    wr_nxt_s        = wr_r;
    din_nxt_s       = din_r;
    pkt_cnt_nxt_s   = pkt_cnt_r;
    stall_cnt_nxt_s = stall_cnt_r;
`ifndef SFIFO_ARB_STRICT_PRIO_EN
    rr_nxt_s        = rr_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (enable && pick_found_s && !fifo_prog_full) begin
          for (int j = 0; j < NSRC; j++) begin
            gnt_nxt_s[j] = (pick_idx_s == IDX_W'(j));
          end
          gnt_idx_nxt_s = pick_idx_s;
          len_nxt_s     = pick_len_clamped_s;
`ifndef SFIFO_ARB_STRICT_PRIO_EN
          rr_nxt_s      = pick_idx_s;
`endif
          state_nxt_s   = ST_HDR0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
        // Time spent blocked by the FIFO, regardless of enable.
        if ((|src_req) && fifo_prog_full && (stall_cnt_r != 16'hFFFF)) begin
          stall_cnt_nxt_s = stall_cnt_r + 16'd1;
        end else begin
          stall_cnt_nxt_s = stall_cnt_r;
        end
      end
      ST_HDR0: begin
        wr_nxt_s    = 1'b1;
        din_nxt_s   = SFIFO_WIDTH'(PID);
        state_nxt_s = ST_HDR1;
      end
      ST_HDR1: begin
        din_nxt_s = SFIFO_WIDTH'(hdr_s);
        idx_nxt_s = '0;
        if (len_r == '0) begin
          done_nxt_s  = gnt_r;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        din_nxt_s = word_s;
        if (idx_r == (len_r - LEN_W'(1))) begin
          done_nxt_s  = gnt_r;
          state_nxt_s = ST_DONE;
        end else begin
          idx_nxt_s   = idx_r + LEN_W'(1);
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_DONE: begin
        wr_nxt_s      = 1'b0;
        gnt_nxt_s     = '0;
        idx_nxt_s     = '0;
        pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
        state_nxt_s   = ST_IDLE;
      end
      default: begin
        wr_nxt_s    = 1'b0;
        gnt_nxt_s   = '0;
        idx_nxt_s   = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Clear wins over any increment in the same cycle.
    if (clr_cnt) begin
      pkt_cnt_nxt_s   = 16'd0;
      stall_cnt_nxt_s = 16'd0;
    end else begin
      pkt_cnt_nxt_s   = pkt_cnt_nxt_s;
      stall_cnt_nxt_s = stall_cnt_nxt_s;
    end

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers; async reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      gnt_r       <= '0;
      gnt_idx_r   <= '0;
      len_r       <= '0;
      idx_r       <= '0;
      done_r      <= '0;
      wr_r        <= 1'b0;
      din_r       <= '0;
      busy_r      <= 1'b0;
      pkt_cnt_r   <= 16'd0;
      stall_cnt_r <= 16'd0;
`ifndef SFIFO_ARB_STRICT_PRIO_EN
      rr_r        <= IDX_W'(NSRC - 1);
`endif
    end else begin
      state_r     <= state_nxt_s;
      gnt_r       <= gnt_nxt_s;
      gnt_idx_r   <= gnt_idx_nxt_s;
      len_r       <= len_nxt_s;
      idx_r       <= idx_nxt_s;
      done_r      <= done_nxt_s;
      wr_r        <= wr_nxt_s;
      din_r       <= din_nxt_s;
      busy_r      <= busy_nxt_s;
      pkt_cnt_r   <= pkt_cnt_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
`ifndef SFIFO_ARB_STRICT_PRIO_EN
      rr_r        <= rr_nxt_s;
`endif
    end
  end

  assign src_gnt      = gnt_r;
  assign src_word_idx = idx_r;
  assign src_done     = done_r;
  assign fifo_wr      = wr_r;
  assign fifo_din     = din_r;
  assign busy         = busy_r;
  assign pkt_cnt      = pkt_cnt_r;
  assign stall_cnt    = stall_cnt_r;

endmodule
